// File: rtl/red_datapath.sv
// Execute/writeback datapath for the reduced RISC-V core: register file, add/sub ALU,
// equality flag for branch resolution, a mirrored a0 register and a committed-write counter.
module red_datapath #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int A0_INDEX      = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic                     RegWrite,
    input  logic                     ALUctrl,
    input  logic                     ALUsrc,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    output logic                     EQ,
    output logic [DATA_WIDTH-1:0]    ALUout,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic [15:0]              wr_count
);

    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(A0_INDEX);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] a0_q;
    logic [DATA_WIDTH-1:0] a0_d;
    logic [15:0]           wr_count_q;
    logic [15:0]           wr_count_d;

    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  do_write;

    // Reads see only pre-edge register contents; x0 is forced to zero on the read side.
    always_comb begin
        rd1 = (rs1 == '0) ? '0 : regs_q[rs1];
        rd2 = (rs2 == '0) ? '0 : regs_q[rs2];
        op_b = ALUsrc ? ImmOp : rd2;
        if (ALUctrl) begin
            alu_result = rd1 - op_b;
        end else begin
            alu_result = rd1 + op_b;
        end
    end

    assign do_write = en & RegWrite & (rd != '0);

    always_comb begin
        regs_d     = regs_q;
        a0_d       = a0_q;
        wr_count_d = wr_count_q;
        if (do_write) begin
            regs_d[rd] = alu_result;
            wr_count_d = wr_count_q + 16'd1;
            if (rd == A0_IDX) begin
                a0_d = alu_result;
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            a0_q       <= '0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            a0_q       <= a0_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign EQ       = (rd1 == op_b);
    assign ALUout   = alu_result;
    assign a0       = a0_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_red_datapath.sv
// Directed self-checking bench for red_datapath: reset, addi chain, x0 protection,
// branch compare, wrap, stall, read-during-write and write-counter wrap.
module tb_red_datapath;

    logic        clk;
    logic        rst;
    logic        en;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        ALUctrl;
    logic        ALUsrc;
    logic [31:0] ImmOp;
    logic        EQ;
    logic [31:0] ALUout;
    logic [31:0] a0;
    logic [15:0] wr_count;

    int errors = 0;
    int checks = 0;

    red_datapath #(
        .ADDRESS_WIDTH(5),
        .DATA_WIDTH(32),
        .A0_INDEX(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .rs1(rs1),
        .rs2(rs2),
        .rd(rd),
        .RegWrite(RegWrite),
        .ALUctrl(ALUctrl),
        .ALUsrc(ALUsrc),
        .ImmOp(ImmOp),
        .EQ(EQ),
        .ALUout(ALUout),
        .a0(a0),
        .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic sub, input logic src,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [4:0] d, input logic [31:0] imm);
        RegWrite = w;
        ALUctrl  = sub;
        ALUsrc   = src;
        rs1      = s1;
        rs2      = s2;
        rd       = d;
        ImmOp    = imm;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b1;
        RegWrite = 1'b0;
        ALUctrl = 1'b0;
        ALUsrc = 1'b0;
        rs1 = '0;
        rs2 = '0;
        rd = '0;
        ImmOp = '0;
        #2;
        checkOutput("reset_a0", a0, 32'h0);
        checkOutput("reset_wr_count", {16'h0, wr_count}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // addi x10, x0, 0xFF then addi x10, x10, 1
        applyStimulus(1, 0, 1, 5'd0, 5'd0, 5'd10, 32'hFF);
        checkOutput("addi1_aluout", ALUout, 32'hFF);
        tick();
        checkOutput("addi1_a0", a0, 32'hFF);
        checkOutput("addi1_wr_count", {16'h0, wr_count}, 32'd1);
        applyStimulus(1, 0, 1, 5'd10, 5'd0, 5'd10, 32'h1);
        checkOutput("addi2_aluout", ALUout, 32'h100);
        tick();
        checkOutput("addi2_a0", a0, 32'h100);
        checkOutput("addi2_wr_count", {16'h0, wr_count}, 32'd2);

        // x0 write is dropped
        applyStimulus(1, 0, 1, 5'd0, 5'd0, 5'd0, 32'h1234);
        tick();
        applyStimulus(0, 0, 1, 5'd0, 5'd0, 5'd0, 32'h0);
        checkOutput("x0_read", ALUout, 32'h0);
        checkOutput("x0_wr_count", {16'h0, wr_count}, 32'd2);

        // branch compare: x1 = 5, x2 = 5, then x2 = 6
        applyStimulus(1, 0, 1, 5'd0, 5'd0, 5'd1, 32'd5);
        tick();
        applyStimulus(1, 0, 1, 5'd0, 5'd0, 5'd2, 32'd5);
        tick();
        applyStimulus(0, 1, 0, 5'd1, 5'd2, 5'd0, 32'hxxxxxxxx);
        checkOutput("beq_equal_eq", {31'h0, EQ}, 32'd1);
        checkOutput("beq_equal_aluout", ALUout, 32'h0);
        applyStimulus(1, 0, 1, 5'd0, 5'd0, 5'd2, 32'd6);
        tick();
        applyStimulus(0, 1, 0, 5'd1, 5'd2, 5'd0, 32'hxxxxxxxx);
        checkOutput("beq_diff_eq", {31'h0, EQ}, 32'd0);
        checkOutput("beq_diff_aluout", ALUout, 32'hFFFFFFFF);
        checkOutput("beq_wr_count", {16'h0, wr_count}, 32'd5);

        // x3 = 0 - 1 = 0xFFFFFFFF, then x3 + 1 wraps to 0
        applyStimulus(1, 1, 1, 5'd0, 5'd0, 5'd3, 32'd1);
        checkOutput("sub_wrap_aluout", ALUout, 32'hFFFFFFFF);
        tick();
        applyStimulus(0, 0, 1, 5'd3, 5'd0, 5'd0, 32'd1);
        checkOutput("add_wrap_aluout", ALUout, 32'h0);
        checkOutput("add_wrap_eq", {31'h0, EQ}, 32'd0);

        // stall: en low blocks the write
        en = 1'b0;
        applyStimulus(1, 0, 1, 5'd3, 5'd0, 5'd3, 32'd1);
        checkOutput("stall_aluout_live", ALUout, 32'h0);
        tick();
        applyStimulus(0, 0, 1, 5'd3, 5'd0, 5'd0, 32'd0);
        checkOutput("stall_x3_held", ALUout, 32'hFFFFFFFF);
        checkOutput("stall_wr_count", {16'h0, wr_count}, 32'd6);
        checkOutput("stall_a0", a0, 32'h100);
        en = 1'b1;

        // read-during-write on x4
        applyStimulus(1, 0, 1, 5'd0, 5'd0, 5'd4, 32'd2);
        tick();
        applyStimulus(1, 0, 1, 5'd4, 5'd0, 5'd4, 32'd3);
        checkOutput("rdw_before_edge", ALUout, 32'd5);
        tick();
        applyStimulus(0, 0, 1, 5'd4, 5'd0, 5'd4, 32'd3);
        checkOutput("rdw_after_edge", ALUout, 32'd8);
        checkOutput("rdw_wr_count", {16'h0, wr_count}, 32'd8);

        // drive wr_count to 0xFFFF and across the wrap
        applyStimulus(1, 0, 1, 5'd0, 5'd0, 5'd6, 32'd9);
        repeat (65527) tick();
        checkOutput("cnt_full", {16'h0, wr_count}, 32'h0000FFFF);
        tick();
        checkOutput("cnt_wrap", {16'h0, wr_count}, 32'h0);

        // mid-run reset after x5 = 7, with a write to x10 pending
        applyStimulus(1, 0, 1, 5'd0, 5'd0, 5'd5, 32'd7);
        tick();
        applyStimulus(0, 0, 0, 5'd5, 5'd0, 5'd0, 32'd0);
        checkOutput("pre_reset_x5", ALUout, 32'd7);
        checkOutput("pre_reset_wr_count", {16'h0, wr_count}, 32'd1);
        applyStimulus(1, 0, 1, 5'd0, 5'd0, 5'd10, 32'h55);
        rst = 1'b0;
        #1;
        applyStimulus(1, 0, 0, 5'd5, 5'd0, 5'd10, 32'h55);
        checkOutput("async_reset_x5", ALUout, 32'h0);
        checkOutput("async_reset_a0", a0, 32'h0);
        checkOutput("async_reset_wr_count", {16'h0, wr_count}, 32'h0);
        tick();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 5'd10, 5'd0, 5'd0, 32'h0);
        checkOutput("reset_drop_x10", ALUout, 32'h0);
        checkOutput("reset_drop_a0", a0, 32'h0);
        checkOutput("reset_drop_wr_count", {16'h0, wr_count}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/red_datapath.md
Name: red_datapath

Overview:
- Execute/writeback half of the reduced RISC-V CPU, and the consumer of the fetch/control block's outputs.
- Takes RegWrite, ALUctrl, ALUsrc and ImmOp plus decoded register indices.
- Holds the architectural register file, performs the ALU operation and writes the result back.
- Returns EQ to the control path for branch resolution and exposes a0 (x10) as the program-visible result.

Parameters:
- ADDRESS_WIDTH, 5, register index width (2**ADDRESS_WIDTH registers).
- DATA_WIDTH, 32, register, immediate and ALU data width.
- A0_INDEX, 10, register mirrored onto the a0 output.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  step enable; when low, no architectural state changes.
- rs1  input  ADDRESS_WIDTH  source register 1 index.
- rs2  input  ADDRESS_WIDTH  source register 2 index.
- rd  input  ADDRESS_WIDTH  destination register index.
- RegWrite  input  1  write ALU result to rd at next edge.
- ALUctrl  input  1  0 = add, 1 = subtract.
- ALUsrc  input  1  0 = operand B is rs2 data, 1 = operand B is ImmOp.
- ImmOp  input  DATA_WIDTH  sign-extended immediate.
- EQ  output  1  1 when rs1 data equals operand B (combinational).
- ALUout  output  DATA_WIDTH  current ALU result (combinational).
- a0  output  DATA_WIDTH  registered copy of register A0_INDEX.
- wr_count  output  16  number of committed register writes, wraps at 2**16.

Behaviour:
- Reset (rst low, asynchronous):
  - All registers, a0 and wr_count clear to 0 immediately, independent of clk.
  - Release is synchronous to the next rising edge.
  - Reset asserted mid-operation discards any in-flight write.
- Reads: rd1 = reg[rs1], rd2 = reg[rs2], combinational. Index 0 always reads 0.
- Operand B: ALUsrc ? ImmOp : rd2.
- ALU:
  - ALUctrl = 0: ALUout = rd1 + B, modulo 2**DATA_WIDTH, carry discarded.
  - ALUctrl = 1: ALUout = rd1 - B, modulo 2**DATA_WIDTH, two's complement wrap.
- EQ = (rd1 == B), independent of ALUctrl. It is valid in the same cycle the inputs are stable and has no latency.
- Write:
  - At a rising edge, reg[rd] <= ALUout if en & RegWrite & (rd != 0).
  - Writes to index 0 are silently dropped and do not increment wr_count.
- Read-during-write, same cycle with rs1 or rs2 == rd:
  - Reads return the pre-edge value; there is no bypass.
  - The new value is visible the cycle after the edge.
- a0 timing:
  - a0 <= value written to A0_INDEX at the same edge as the register write, so a0 equals reg[A0_INDEX] one cycle after the write edge.
  - a0 holds otherwise.
- wr_count increments by 1 on every committed write (rules above) and wraps 0xFFFF -> 0x0000.
- en low:
  - Register file, a0 and wr_count hold.
  - EQ and ALUout still track inputs combinationally.
- Simultaneous events: asynchronous reset dominates any write in the same cycle. X on unused inputs (ImmOp when ALUsrc = 0) must not propagate to outputs.
- No multicycle state: every instruction completes in one en-qualified cycle.

Test Plan:
- Reset values: pull rst low mid-run after writing x5 = 7 -> all registers read 0, a0 = 0, wr_count = 0 before the next clk edge.
- addi chain: rs1 = 0, rd = 10, ALUsrc = 1, ImmOp = 0xFF, RegWrite = 1, ALUctrl = 0, one edge. Then rs1 = 10, rd = 10, ImmOp = 1 -> a0 = 0xFF, then 0x100; wr_count = 2.
- x0 protection: write rd = 0 with ImmOp = 0x1234 -> reading rs1 = 0 gives 0, wr_count unchanged.
- Branch compare:
  - x1 = 5, x2 = 5, ALUsrc = 0, ALUctrl = 1 -> EQ = 1, ALUout = 0.
  - Set x2 = 6 -> EQ = 0, ALUout = 0xFFFFFFFF.
- Wrap and stall:
  - x3 = 0xFFFFFFFF plus ImmOp 1 -> ALUout = 0.
  - en = 0 with RegWrite = 1 -> x3 and wr_count unchanged.
  - wr_count preloaded to 0xFFFF via 65535 writes -> next write gives 0x0000.
- Read-during-write: rs1 = rd = 4, x4 = 2, ImmOp = 3, add -> ALUout = 5 before the edge and 8 after the edge.
